// File: rtl/net_pkg.sv
// Shared definitions for the network transmit arbiter: FSM encoding and default word width.
package net_pkg;

  localparam int unsigned NET_BITS = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StFlush = 2'd2
  } net_state_e;

endpackage

// File: rtl/net_rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after 'last', wrapping.
module net_rr_pick
  import net_pkg::*;
#(
  parameter int unsigned PORTS = 4,
  localparam int unsigned PW = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [PW-1:0]    last,
  output logic             found,
  output logic [PW-1:0]    idx
);

  always_comb begin
    int unsigned cand;
    logic [PW-1:0] cidx;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    cidx  = '0;
    // Offsets 1..PORTS so the last winner is considered only after every other port.
    for (int k = 1; k <= int'(PORTS); k++) begin
      cand = (int'(last) + k) % PORTS;
      cidx = cand[PW-1:0];
      if (!found && req[cidx]) begin
        found = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/net_tx_arb.sv
// Frame-atomic round-robin arbiter feeding one registered word stream toward a link transmitter.
module net_tx_arb
  import net_pkg::*;
#(
  parameter int unsigned BITS    = NET_BITS,
  parameter int unsigned PORTS   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         in_valid,
  input  logic [PORTS*BITS-1:0]    in_data,
  input  logic [PORTS-1:0]         in_end,
  output logic [PORTS-1:0]         in_pull,
  input  logic [PORTS-1:0]         enable,
  output logic                     out_valid,
  output logic [BITS-1:0]          out_data,
  output logic                     out_end,
  input  logic                     out_pull,
  output logic [$clog2(PORTS)-1:0] out_port,
  output logic                     timeout_err,
  output logic [15:0]              frame_count
);

  localparam int unsigned PW = $clog2(PORTS);
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  net_state_e    state_q, state_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [PW-1:0] last_q, last_d;
  logic [SW-1:0] stall_q, stall_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic            loadable;
  logic            cur_valid;
  logic            cur_end;
  logic            xfer;
  logic [BITS-1:0] words [PORTS];

  logic            load;
  logic [BITS-1:0] load_data;
  logic            load_end;
  logic            flush_pulse;

  for (genvar g = 0; g < PORTS; g++) begin : g_words
    assign words[g] = in_data[g*BITS +: BITS];
  end

  net_rr_pick #(
    .PORTS (PORTS)
  ) u_pick (
    .req   (in_valid & enable),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign loadable  = !out_valid || out_pull;
  assign cur_valid = in_valid[grant_q];
  assign cur_end   = in_end[grant_q];
  assign xfer      = in_pull[grant_q] && cur_valid;

  always_comb begin
    in_pull = '0;
    if (state_q == StBusy && loadable) begin
      in_pull[grant_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    stall_d     = stall_q;
    load        = 1'b0;
    load_data   = '0;
    load_end    = 1'b0;
    flush_pulse = 1'b0;
    unique case (state_q)
      StIdle: begin
        stall_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (xfer) begin
          stall_d   = '0;
          load      = 1'b1;
          load_data = words[grant_q];
          load_end  = cur_end;
          if (cur_end) begin
            state_d = StIdle;
            last_d  = grant_q;
          end
        end else if (in_pull[grant_q]) begin
          // Only a source that could have sent but did not counts as stalled.
          if (stall_q == SW'(TIMEOUT - 1)) begin
            stall_d = SW'(TIMEOUT);
            state_d = StFlush;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      StFlush: begin
        if (loadable) begin
          load        = 1'b1;
          load_end    = 1'b1;
          flush_pulse = 1'b1;
          last_d      = grant_q;
          stall_d     = '0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= PW'(PORTS - 1);
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_end     <= 1'b0;
      out_port    <= '0;
      timeout_err <= 1'b0;
      frame_count <= '0;
    end else begin
      timeout_err <= flush_pulse;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_end   <= load_end;
        out_port  <= grant_q;
        if (load_end) begin
          frame_count <= frame_count + 16'd1;
        end
      end else if (out_pull) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
